// File: rtl/fb_draw_pkg.sv
// Shared types for the frame-buffer write scheduler: FSM states and the
// image codes used by the game controller's display field.
package fb_draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAW,
        DONE
    } state_t;

    localparam logic [2:0] IMG_D0    = 3'd0;
    localparam logic [2:0] IMG_D1    = 3'd1;
    localparam logic [2:0] IMG_D2    = 3'd2;
    localparam logic [2:0] IMG_D3    = 3'd3;
    localparam logic [2:0] IMG_START = 3'd4;
    localparam logic [2:0] IMG_OVER  = 3'd5;
    localparam logic [2:0] IMG_BLANK = 3'd6;

    localparam int NUM_IMG = 6;

endpackage

// File: rtl/fb_draw_sched_raster_counter.sv
// Raster-order x/y counter with run-time limits, so one instance can walk
// either the full screen or the glyph box.
module raster_counter #(
    parameter int W  = 320,
    parameter int H  = 240,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [XW-1:0] x_lim,
    input  logic [YW-1:0] y_lim,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_last;
    logic y_last;

    assign x_last = (x == x_lim);
    assign y_last = (y == y_lim);
    assign last   = x_last && y_last;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_draw_sched.sv
// Arbitrates the single frame-buffer write port between a full-screen clear
// and a glyph copy from the 1-bit glyph ROM into a fixed screen box.
module fb_draw_sched
    import fb_draw_pkg::*;
#(
    parameter int SCR_W   = 320,
    parameter int SCR_H   = 240,
    parameter int GLYPH_W = 64,
    parameter int GLYPH_H = 64,
    parameter int X0      = 128,
    parameter int Y0      = 88,
    parameter int ROM_AW  = $clog2(NUM_IMG * GLYPH_W * GLYPH_H),
    parameter int XW      = $clog2(SCR_W),
    parameter int YW      = $clog2(SCR_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              draw_req,
    input  logic [2:0]        draw_img,
    output logic              req_ack,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_data,
    output logic [XW-1:0]     fb_x,
    output logic [YW-1:0]     fb_y,
    output logic              fb_color,
    output logic              fb_we
);

    if (X0 + GLYPH_W > SCR_W || Y0 + GLYPH_H > SCR_H) begin : g_box_check
        $error("glyph box does not fit on the screen");
    end

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    img_q;
    logic          blank;
    logic          cnt_en;
    logic          cnt_clr;
    logic          cnt_last;
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;
    logic [XW-1:0] x_lim;
    logic [YW-1:0] y_lim;
    logic [XW-1:0] gx_p1;
    logic [YW-1:0] gy_p1;
    logic          last_p1;
    int            rom_base;

    assign blank   = (img_q >= IMG_BLANK);
    assign cnt_clr = (state == IDLE);
    assign cnt_en  = (state == CLEAR) || (state == FETCH) || (state == DRAW);
    assign x_lim   = (state == CLEAR) ? XW'(SCR_W - 1) : XW'(GLYPH_W - 1);
    assign y_lim   = (state == CLEAR) ? YW'(SCR_H - 1) : YW'(GLYPH_H - 1);
    assign rom_base = blank ? 0 : int'(img_q) * GLYPH_W * GLYPH_H;

    raster_counter #(
        .W  (SCR_W),
        .H  (SCR_H),
        .XW (XW),
        .YW (YW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .x_lim (x_lim),
        .y_lim (y_lim),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
                     else if (draw_req) state_nxt = FETCH;
            CLEAR:   if (cnt_last) state_nxt = DONE;
            FETCH:   state_nxt = DRAW;
            DRAW:    if (last_p1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && !clr_req && draw_req) img_q <= draw_img;
    end

    // p1: ROM address presented last cycle; its pixel arrives on rom_data now
    always_ff @(posedge clk) begin
        gx_p1 <= cnt_x;
        gy_p1 <= cnt_y;
    end

    always_ff @(posedge clk) begin
        if (reset) last_p1 <= 1'b0;
        else       last_p1 <= ((state == FETCH) || (state == DRAW)) && cnt_last;
    end

    always_comb begin
        req_ack  = 1'b0;
        busy     = (state != IDLE);
        done     = 1'b0;
        rom_addr = '0;
        fb_x     = '0;
        fb_y     = '0;
        fb_color = 1'b0;
        fb_we    = 1'b0;
        case (state)
            IDLE:  req_ack = (clr_req || draw_req) && !reset;
            CLEAR: begin
                fb_we = !reset;
                fb_x  = cnt_x;
                fb_y  = cnt_y;
            end
            FETCH: rom_addr = ROM_AW'(rom_base + int'(cnt_y) * GLYPH_W + int'(cnt_x));
            DRAW: begin
                rom_addr = ROM_AW'(rom_base + int'(cnt_y) * GLYPH_W + int'(cnt_x));
                fb_we    = !reset;
                fb_x     = XW'(X0 + int'(gx_p1));
                fb_y     = YW'(Y0 + int'(gy_p1));
                fb_color = blank ? 1'b0 : rom_data;
            end
            DONE:    done = !reset;
            default: ;
        endcase
    end

endmodule

// File: doc/fb_draw_sched.md
Name: fb_draw_sched

Overview:
- Sequences the single frame-buffer write port between two requesters: a full-screen clear engine and a glyph draw engine.
- The glyph draw engine copies one image (digit 0-3, start screen, game over) from a 1-bit glyph ROM into a fixed screen box.
- Sits between the game controller (display/clear outputs) and the VGA frame buffer.
- Guarantees one writer at a time, with a req/ack/done handshake.

Parameters:
- SCR_W, 320, screen width in pixels
- SCR_H, 240, screen height in pixels
- GLYPH_W, 64, glyph box width
- GLYPH_H, 64, glyph box height
- X0, 128, glyph box left column
- Y0, 88, glyph box top row

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- clr_req  in  1  request full-screen clear; held until req_ack
- draw_req  in  1  request glyph draw; held until req_ack
- draw_img  in  3  image code; valid with draw_req
- req_ack  out  1  one-cycle pulse; request accepted
- busy  out  1  engine not idle
- done  out  1  one-cycle pulse; operation complete
- rom_addr  out  ROM_AW  glyph ROM address, where ROM_AW = $clog2(6*GLYPH_W*GLYPH_H)
- rom_data  in  1  glyph ROM pixel; valid 1 cycle after rom_addr
- fb_x  out  $clog2(SCR_W)  write column
- fb_y  out  $clog2(SCR_H)  write row
- fb_color  out  1  pixel value (1 = white)
- fb_we  out  1  frame-buffer write enable

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: req_ack=0, busy=0, done=0, fb_we=0, fb_x=0, fb_y=0, fb_color=0, rom_addr=0. State = IDLE.
- States: IDLE, CLEAR, FETCH, DRAW, DONE. busy = (state != IDLE).
- IDLE:
  - Requests are sampled only here.
  - clr_req has priority over draw_req. A losing request is not acked and must stay held; it is accepted in the first IDLE cycle after DONE.
  - On accept: req_ack=1 in that cycle and draw_img is latched. Next state is CLEAR (clear) or FETCH (draw).
- CLEAR:
  - One write per cycle, color 0, raster order: x 0..SCR_W-1 inner loop, y 0..SCR_H-1 outer loop.
  - After the write at (SCR_W-1, SCR_H-1), go to DONE.
  - First fb_we is at T+1, where T is the ack cycle.
- FETCH (1 cycle): present rom_addr = img*GLYPH_W*GLYPH_H + 0; no write.
- DRAW:
  - Each cycle: write the pixel whose address was presented in the previous cycle, and present the next address.
  - fb_x = X0+gx, fb_y = Y0+gy, fb_color = rom_data. gx and gy are pipelined one stage alongside rom_addr.
  - First fb_we is at T+2. Exactly GLYPH_W*GLYPH_H writes, then DONE.
- Images 6 and 7: draw blank. The same box is written in the same number of cycles with fb_color forced to 0; rom_data is ignored.
- DONE (1 cycle): done=1, busy=1, fb_we=0; then IDLE.
- Latencies:
  - Clear: done at T+SCR_W*SCR_H+1.
  - Draw: done at T+GLYPH_W*GLYPH_H+2.
- Requests arriving while busy are ignored (not acked, not queued).
- Counters: a counter wraps to 0 at the last column/row. The last flag is asserted combinationally.
- Box bounds: X0+GLYPH_W <= SCR_W and Y0+GLYPH_H <= SCR_H. Checked by an elaboration assertion.
- Reset mid-operation: state returns to IDLE next edge, fb_we=0 from that cycle, no done pulse. The interrupted operation is abandoned.

Decomposition:
- Package fb_draw_pkg:
  - State enum.
  - Image codes matching the controller display field: IMG_D0..IMG_D3 = 0..3, IMG_START = 4, IMG_OVER = 5, IMG_BLANK = 6.
  - Localparam NUM_IMG = 6.
- Sub-module raster_counter (params W, H): x/y counters with enable, clear, and last flag. Used once, shared by CLEAR and DRAW.

Test Plan (SCR_W=8, SCR_H=4, GLYPH_W=4, GLYPH_H=2, X0=2, Y0=1):
1. Reset asserted 2 cycles with random requests -> all outputs 0, no req_ack.
2. clr_req at T -> req_ack at T; fb_we T+1..T+32 covering (0,0)..(7,3) in raster order, color 0; done at T+33; busy low at T+34.
3. draw_req img=2, ROM pixel = addr[0] -> rom_addr=16 at T+1; writes T+2..T+9 at (2,1),(3,1),(4,1),(5,1),(2,2)..(5,2) with colors 0,1,0,1,0,1,0,1; done at T+10.
4. clr_req and draw_req both at T -> clear acked at T; draw_req held, acked at T+34, first draw write at T+36.
5. draw_img=7 with rom_data=1 -> 8 writes over the box, all color 0; done at T+10.
6. Reset at the 10th clear write -> fb_we=0 and busy=0 the next cycle, no done; a new draw_req is acked the cycle after reset deasserts.
